pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline.
//  - Detects load-use hazards and inserts ID/EX bubbles.
//  - Flushes IF/ID on redirects (branch/J/JAL/JR).
//  - Freezes the whole pipe while data memory is busy and feeds bubbles into MEM/WB.
//  - Counts stall cycles, and latches a sticky timeout error if memory never responds.
// PARAMETERS
//  MEM_TIMEOUT  16  consecutive not-ready cycles before the error state is entered
//  CNT_W        16  width of the Stall_Count performance counter
// PORTS
//  Clk_in           in   1      clock, rising edge
//  Rst              in   1      asynchronous, active-low reset
//  IDEX_MemRead     in   1      instruction in EX is a load
//  IDEX_Rt          in   5      load destination register in EX
//  IFID_Rs          in   5      rs of instruction in ID
//  IFID_Rt          in   5      rt of instruction in ID
//  IFID_UsesRt      in   1      ID instruction reads rt as a source
//  EXMEM_MemAccess  in   1      MEM-stage instruction reads or writes data memory
//  DMem_Ready       in   1      data memory completes the access this cycle
//  Redirect         in   1      ID resolved a taken branch, J, JAL or JR
//  PC_Write         out  1      PC update enable
//  IFID_Write       out  1      IF/ID load enable
//  IFID_Flush       out  1      clear IF/ID to NOP on this edge
//  IDEX_Bubble      out  1      load NOP controls into ID/EX
//  Pipe_Hold        out  1      hold ID/EX and EX/MEM contents
//  MEMWB_Bubble     out  1      load RegWrite=0 / MemtoReg=0 into MEM/WB
//  DMem_Timeout     out  1      sticky error flag; cleared only by reset
//  Stall_Count      out  CNT_W  stall cycles since reset; saturating
// BEHAVIOUR
//  Reset: while Rst=0, every output is forced to 0. This includes PC_Write and IFID_Write.
//   FSM returns to RUN; wait_cnt=0; Stall_Count=0; DMem_Timeout=0.
//  FSM states: RUN, MEM_WAIT, ERR. wait_cnt has width $clog2(MEM_TIMEOUT+1).
//  mem_busy   = EXMEM_MemAccess & ~DMem_Ready.
//  load_use   = IDEX_MemRead & (IDEX_Rt!=0) & ((IDEX_Rt==IFID_Rs) | (IFID_UsesRt & IDEX_Rt==IFID_Rt)).
//  Outputs are combinational (Mealy) from state and inputs, except DMem_Timeout and Stall_Count (registered).
//  Priority, highest first: ERR > mem_busy > load_use > Redirect > normal.
//   ERR:      Pipe_Hold=1, MEMWB_Bubble=1, PC_Write=0, IFID_Write=0.
//             Other outputs are 0. The block stays in ERR until reset.
//   mem_busy: Pipe_Hold=1, MEMWB_Bubble=1, PC_Write=0, IFID_Write=0, IFID_Flush=0, IDEX_Bubble=0.
//   load_use: PC_Write=0, IFID_Write=0, IDEX_Bubble=1, Pipe_Hold=0, IFID_Flush=0.
//             Redirect is ignored this cycle and is re-evaluated next cycle.
//   Redirect: PC_Write=1, IFID_Write=1, IFID_Flush=1.
//   normal:   PC_Write=1, IFID_Write=1; all other outputs 0.
//  RUN transitions:
//   - mem_busy -> MEM_WAIT, wait_cnt<=1.
//   - otherwise stay in RUN, wait_cnt<=0.
//  MEM_WAIT transitions:
//   - mem_busy & wait_cnt==MEM_TIMEOUT -> ERR, DMem_Timeout<=1.
//   - mem_busy otherwise -> stay, wait_cnt<=wait_cnt+1.
//   - ~mem_busy (Ready seen, or access dropped) -> RUN, wait_cnt<=0.
//     The hold releases in the same cycle Ready is high.
//  ERR is therefore entered on the edge that closes not-ready cycle MEM_TIMEOUT+1.
//  Stall_Count increments on each edge where Pipe_Hold | load_use (as qualified above) is true.
//   It saturates at {CNT_W{1'b1}} and does not wrap.
//  Reset asserted mid-wait: FSM returns to RUN immediately (asynchronous).
//   Counters clear; no timeout is flagged.
// TESTING
//  1. Load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8
//     -> PC_Write=0, IFID_Write=0, IDEX_Bubble=1 for exactly that cycle; Stall_Count 0->1.
//  2. $zero and unused rt: IDEX_Rt=0=IFID_Rs -> no stall.
//     IDEX_Rt=9=IFID_Rt with IFID_UsesRt=0 -> no stall.
//  3. Redirect=1 with no hazard -> IFID_Flush=1, PC_Write=1.
//     Redirect=1 together with load_use -> IFID_Flush=0, IDEX_Bubble=1.
//  4. EXMEM_MemAccess=1, DMem_Ready=0 for 5 cycles, then 1
//     -> Pipe_Hold=1 and MEMWB_Bubble=1 for 5 cycles; Pipe_Hold=0 in the Ready cycle; Stall_Count +=5.
//  5. DMem_Ready held 0 for 17 cycles (MEM_TIMEOUT=16) -> DMem_Timeout=1 after edge 17, sticky.
//     Pipe_Hold=1 even after Ready=1. Same test with 16 cycles -> no timeout.
//  6. Rst pulsed low during MEM_WAIT -> all outputs 0 asynchronously.
//     After release: RUN, Stall_Count=0. Saturation check with CNT_W=4: counter stays at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline.
//   - Load-use hazards: freeze PC and IF/ID, and inject a bubble into ID/EX.
//   - Redirects (taken branch, J, JAL, JR): flush IF/ID.
//   - Data memory busy: freeze the whole pipe and feed bubbles into MEM/WB.
//   - Counts stall cycles (saturating) and latches a sticky timeout error
//     if memory stays not-ready for more than MEM_TIMEOUT consecutive cycles.
//
// Parameters
//   MEM_TIMEOUT  consecutive not-ready cycles tolerated before the error state
//   CNT_W        width of the Stall_Count performance counter
//
// Ports
//   Clk_in           in   clock, rising edge
//   Rst              in   asynchronous, active-low reset
//   IDEX_MemRead     in   instruction in EX is a load
//   IDEX_Rt          in   load destination register in EX
//   IFID_Rs          in   rs of instruction in ID
//   IFID_Rt          in   rt of instruction in ID
//   IFID_UsesRt      in   ID instruction reads rt as a source
//   EXMEM_MemAccess  in   MEM-stage instruction accesses data memory
//   DMem_Ready       in   data memory completes the access this cycle
//   Redirect         in   ID resolved a taken branch, J, JAL or JR
//   PC_Write         out  PC update enable
//   IFID_Write       out  IF/ID load enable
//   IFID_Flush       out  clear IF/ID to NOP on this edge
//   IDEX_Bubble      out  load NOP controls into ID/EX
//   Pipe_Hold        out  hold ID/EX and EX/MEM contents
//   MEMWB_Bubble     out  load RegWrite=0 / MemtoReg=0 into MEM/WB
//   DMem_Timeout     out  sticky error flag, cleared only by reset
//   Stall_Count      out  saturating count of stall cycles since reset

module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             Clk_in,
    input  logic             Rst,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_Rt,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             EXMEM_MemAccess,
    input  logic             DMem_Ready,
    input  logic             Redirect,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             Pipe_Hold,
    output logic             MEMWB_Bubble,
    output logic             DMem_Timeout,
    output logic [CNT_W-1:0] Stall_Count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic              timeout_q, timeout_d;

    logic mem_busy;
    logic load_use;

    // Ungated control decisions; the reset gating is applied only at the
    // output ports so that Rst never feeds the flop data paths.
    logic pc_write_raw;
    logic ifid_write_raw;
    logic ifid_flush_raw;
    logic idex_bubble_raw;
    logic pipe_hold_raw;
    logic memwb_bubble_raw;

    // Hazard detection. Register $zero can never create a dependency, and
    // rt only matters when the ID instruction actually reads it.
    always_comb begin
        mem_busy = EXMEM_MemAccess & ~DMem_Ready;
        load_use = IDEX_MemRead & (IDEX_Rt != 5'd0) &
                   ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt)));
    end

    // Mealy control outputs, highest priority first. A load-use stall
    // suppresses the redirect flush; the redirect is re-presented next cycle
    // once the bubble has resolved the hazard.
    always_comb begin
        pc_write_raw     = 1'b0;
        ifid_write_raw   = 1'b0;
        ifid_flush_raw   = 1'b0;
        idex_bubble_raw  = 1'b0;
        pipe_hold_raw    = 1'b0;
        memwb_bubble_raw = 1'b0;
        if (state_q == ERR) begin
            pipe_hold_raw    = 1'b1;
            memwb_bubble_raw = 1'b1;
        end else if (mem_busy) begin
            pipe_hold_raw    = 1'b1;
            memwb_bubble_raw = 1'b1;
        end else if (load_use) begin
            idex_bubble_raw  = 1'b1;
        end else if (Redirect) begin
            pc_write_raw     = 1'b1;
            ifid_write_raw   = 1'b1;
            ifid_flush_raw   = 1'b1;
        end else begin
            pc_write_raw     = 1'b1;
            ifid_write_raw   = 1'b1;
        end
    end

    // While reset is asserted every output, including the enables, is 0.
    always_comb begin
        PC_Write     = pc_write_raw & Rst;
        IFID_Write   = ifid_write_raw & Rst;
        IFID_Flush   = ifid_flush_raw & Rst;
        IDEX_Bubble  = idex_bubble_raw & Rst;
        Pipe_Hold    = pipe_hold_raw & Rst;
        MEMWB_Bubble = memwb_bubble_raw & Rst;
        DMem_Timeout = timeout_q;
        Stall_Count  = stall_count_q;
    end

    // Memory-wait sequencing. wait_cnt holds the number of not-ready cycles
    // already closed, so the edge ending not-ready cycle MEM_TIMEOUT+1 is the
    // one that finds wait_cnt == MEM_TIMEOUT and moves to ERR.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d   = ERR;
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Stall counter: any held or bubbled cycle counts, including the cycles
    // spent frozen in ERR. It sticks at all-ones instead of wrapping.
    always_comb begin
        stall_count_d = stall_count_q;
        if ((pipe_hold_raw | idex_bubble_raw) && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk_in or negedge Rst) begin
        if (!Rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            stall_count_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            timeout_q     <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   localparam int MEM_TIMEOUT = 16;

   logic Clk_in = 1'b0;
   always #5 Clk_in = ~Clk_in;

   logic       Rst;
   logic       IDEX_MemRead;
   logic [4:0] IDEX_Rt;
   logic [4:0] IFID_Rs;
   logic [4:0] IFID_Rt;
   logic       IFID_UsesRt;
   logic       EXMEM_MemAccess;
   logic       DMem_Ready;
   logic       Redirect;

   logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Hold, MEMWB_Bubble, DMem_Timeout;
   logic [15:0] Stall_Count;
   logic        smallPcWrite, smallIfidWrite, smallIfidFlush, smallIdexBubble, smallPipeHold, smallMemwbBubble, smallTimeout;
   logic [3:0]  smallStallCount;

   // Default-width instance
   pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(16)) dut (
      .Clk_in(Clk_in), .Rst(Rst),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
      .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
      .EXMEM_MemAccess(EXMEM_MemAccess), .DMem_Ready(DMem_Ready), .Redirect(Redirect),
      .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
      .IDEX_Bubble(IDEX_Bubble), .Pipe_Hold(Pipe_Hold), .MEMWB_Bubble(MEMWB_Bubble),
      .DMem_Timeout(DMem_Timeout), .Stall_Count(Stall_Count)
   );

   // Narrow-counter instance, used to exercise counter saturation
   pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) dutSmall (
      .Clk_in(Clk_in), .Rst(Rst),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
      .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
      .EXMEM_MemAccess(EXMEM_MemAccess), .DMem_Ready(DMem_Ready), .Redirect(Redirect),
      .PC_Write(smallPcWrite), .IFID_Write(smallIfidWrite), .IFID_Flush(smallIfidFlush),
      .IDEX_Bubble(smallIdexBubble), .Pipe_Hold(smallPipeHold), .MEMWB_Bubble(smallMemwbBubble),
      .DMem_Timeout(smallTimeout), .Stall_Count(smallStallCount)
   );

   // ctrl = {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Hold, MEMWB_Bubble}
   typedef struct {
      logic [5:0]  ctrl;
      logic        timeout;
      logic [15:0] cnt16;
      logic [3:0]  cnt4;
   } expect_t;

   expect_t scoreQ[$];
   int compared   = 0;
   int mismatched = 0;

   // Reference model state: error flag, length of the current run of
   // not-ready cycles, and an unbounded stall total.
   bit      mErr      = 1'b0;
   int      mBusyRun  = 0;
   longint  mStall    = 0;

   // Drives one cycle of inputs, queues the expected response, then advances
   // the model across the following rising edge.
   task automatic applyStimulus(input bit rst, input bit mr, input logic [4:0] exRt,
                                input logic [4:0] idRs, input logic [4:0] idRt,
                                input bit usesRt, input bit acc, input bit rdy, input bit redir);
      expect_t e;
      bit memBusy, loadUse;
      Rst = rst; IDEX_MemRead = mr; IDEX_Rt = exRt; IFID_Rs = idRs; IFID_Rt = idRt;
      IFID_UsesRt = usesRt; EXMEM_MemAccess = acc; DMem_Ready = rdy; Redirect = redir;
      if (!rst) begin
         mErr = 1'b0; mBusyRun = 0; mStall = 0;
      end
      memBusy = acc && !rdy;
      loadUse = mr && (exRt != 5'd0) && ((exRt == idRs) || (usesRt && (exRt == idRt)));
      if (!rst)          e.ctrl = 6'b000000;
      else if (mErr)     e.ctrl = 6'b000011;
      else if (memBusy)  e.ctrl = 6'b000011;
      else if (loadUse)  e.ctrl = 6'b000100;
      else if (redir)    e.ctrl = 6'b111000;
      else               e.ctrl = 6'b110000;
      e.timeout = mErr;
      e.cnt16 = (mStall > 64'd65535) ? 16'hFFFF : 16'(mStall);
      e.cnt4  = (mStall > 64'd15) ? 4'hF : 4'(mStall);
      scoreQ.push_back(e);
      @(posedge Clk_in);
      #1;
      if (rst) begin
         if (e.ctrl[2] || e.ctrl[1]) mStall++;
         if (!mErr) begin
            if (memBusy) begin
               mBusyRun++;
               if (mBusyRun > MEM_TIMEOUT) mErr = 1'b1;
            end else begin
               mBusyRun = 0;
            end
         end
      end
   endtask

   task automatic checkOutput(input expect_t e);
      logic [5:0] act;
      logic [5:0] actSmall;
      act      = {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Hold, MEMWB_Bubble};
      actSmall = {smallPcWrite, smallIfidWrite, smallIfidFlush, smallIdexBubble, smallPipeHold, smallMemwbBubble};
      compared++;
      if (act !== e.ctrl) begin
         mismatched++;
         $display("[TB] FAIL ctrl t=%0t actual=%b required=%b", $time, act, e.ctrl);
      end
      compared++;
      if (actSmall !== e.ctrl) begin
         mismatched++;
         $display("[TB] FAIL ctrlSmall t=%0t actual=%b required=%b", $time, actSmall, e.ctrl);
      end
      compared++;
      if (DMem_Timeout !== e.timeout || smallTimeout !== e.timeout) begin
         mismatched++;
         $display("[TB] FAIL timeout t=%0t actual=%b/%b required=%b", $time, DMem_Timeout, smallTimeout, e.timeout);
      end
      compared++;
      if (Stall_Count !== e.cnt16) begin
         mismatched++;
         $display("[TB] FAIL count16 t=%0t actual=%0d required=%0d", $time, Stall_Count, e.cnt16);
      end
      compared++;
      if (smallStallCount !== e.cnt4) begin
         mismatched++;
         $display("[TB] FAIL count4 t=%0t actual=%0d required=%0d", $time, smallStallCount, e.cnt4);
      end
   endtask

   // Monitor: every cycle presents a response, sampled on the falling edge
   initial begin
      forever begin
         @(negedge Clk_in);
         if (scoreQ.size() > 0) checkOutput(scoreQ.pop_front());
      end
   end

   task automatic normalCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
   endtask

   task automatic busyCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
   endtask

   initial begin
      Rst = 1'b0; IDEX_MemRead = 1'b0; IDEX_Rt = '0; IFID_Rs = '0; IFID_Rt = '0;
      IFID_UsesRt = 1'b0; EXMEM_MemAccess = 1'b0; DMem_Ready = 1'b1; Redirect = 1'b0;
      @(posedge Clk_in);
      #1;

      // Reset forces all outputs low even with hazard-like inputs
      applyStimulus(0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 1);
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
      normalCycles(2);

      // Load-use on rs, then rt-only cases
      applyStimulus(1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 1, 0);
      normalCycles(1);
      applyStimulus(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
      applyStimulus(1, 1, 5'd9, 5'd3, 5'd9, 0, 0, 1, 0);
      applyStimulus(1, 1, 5'd9, 5'd3, 5'd9, 1, 0, 1, 0);

      // Redirect alone, then with a load-use hazard
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
      applyStimulus(1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 1, 1);
      applyStimulus(1, 0, 5'd8, 5'd8, 5'd0, 0, 0, 1, 1);

      // Memory busy for 5 cycles, then ready
      busyCycles(5);
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0);
      normalCycles(1);

      // 16 not-ready cycles: no timeout
      busyCycles(16);
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1);
      normalCycles(2);

      // 17 not-ready cycles: sticky timeout, hold persists after ready
      busyCycles(17);
      applyStimulus(1, 1, 5'd8, 5'd8, 5'd0, 0, 1, 1, 1);
      normalCycles(3);

      // Reset clears the error
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
      normalCycles(1);

      // Reset asserted mid-wait, asynchronously
      busyCycles(4);
      applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
      normalCycles(1);
      busyCycles(2);
      applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0);

      // Randomized traffic with small register indices to provoke matches
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 299) != 0,
                       $urandom_range(0, 1) != 0,
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       $urandom_range(0, 1) != 0,
                       $urandom_range(0, 3) == 0,
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) == 0);
      end

      @(negedge Clk_in);
      #1;
      if (scoreQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL drain actual=%0d pending required=0", scoreQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
